// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_CODE_DEFAULT = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_e;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a value source and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                   start;
    logic [BIN_W-1:0]       bin;
    logic                   blank_lz;
    logic                   busy;
    logic                   done;
    logic [DIGITS-1:0][3:0] digits;

    modport master (output start, bin, blank_lz, input busy, done, digits);
    modport slave  (input start, bin, blank_lz, output busy, done, digits);
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock, with
// optional leading-zero blanking and a start/busy/done handshake.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int         BIN_W      = 16,
    parameter int         DIGITS     = 5,
    parameter bcd_digit_t BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(BIN_W + 1);

    generate
        if (DIGITS < (BIN_W * 301) / 1000 + 1) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    conv_state_e                state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [BIN_W-1:0]           shreg_q, shreg_d;
    bcd_digit_t [DIGITS-1:0]    scr_q, scr_d;
    bcd_digit_t [DIGITS-1:0]    digits_q, digits_d;
    logic                       blank_q, blank_d;
    logic                       done_q, done_d;

    bcd_digit_t [DIGITS-1:0]    adj;
    bcd_digit_t [DIGITS-1:0]    scr_sh;
    bcd_digit_t [DIGITS-1:0]    blanked;
    logic                       seen_nz;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (.d_i(scr_q[g]), .d_o(adj[g]));
        end
    endgenerate

    // The top digit's MSB falls off; DIGITS is sized so it is always zero here.
    assign scr_sh = (DIGITS*4)'({adj, shreg_q[BIN_W-1]});

    always_comb begin
        blanked = scr_sh;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scr_sh[i] != 4'd0) seen_nz = 1'b1;
            if (blank_q && !seen_nz) blanked[i] = BLANK_CODE;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        scr_d    = scr_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shreg_d = bus.bin;
                    scr_d   = '0;
                    blank_d = bus.blank_lz;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d   = scr_sh;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    digits_d = blanked;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            scr_q    <= '0;
            digits_q <= '0;
            blank_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            scr_q    <= scr_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == ST_SHIFT);
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of bin_to_bcd_seq against a div/mod reference.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   lat, bsy;
    logic [15:0] rv;
    logic        rb;
    logic        seen_done;

    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus ();

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .BLANK_CODE(4'hF)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int unsigned v, input bit blz);
        logic [19:0] r;
        int unsigned t;
        bit nz;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (blz) begin
            nz = 1'b0;
            for (int i = 4; i >= 1; i--) begin
                if (r[i*4 +: 4] != 4'd0) nz = 1'b1;
                if (!nz) r[i*4 +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with busy=0; returns after the done sample.
    task automatic convert(input logic [15:0] v, input logic blz, output int l, output int b);
        bus.bin = v;
        bus.blank_lz = blz;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        l = 0;
        b = 0;
        while (!bus.done && l < 40) begin
            if (bus.busy) b++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bin = '0;
        bus.blank_lz = 1'b0;
        #22 resetn = 1'b1;
        @(posedge clk); #1;

        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_digits", 32'(bus.digits), 0);

        // zero value, no blanking
        convert(16'd0, 1'b0, lat, bsy);
        check("zero_lat", lat, 16);
        check("zero_digits", 32'(bus.digits), 32'h00000);

        // full-scale value
        convert(16'hFFFF, 1'b0, lat, bsy);
        check("max_lat", lat, 16);
        check("max_busy_cycles", bsy, 16);
        check("max_digits", 32'(bus.digits), 32'h65535);
        check("max_done_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        check("max_done_pulse", 32'(bus.done), 0);
        check("max_hold", 32'(bus.digits), 32'h65535);

        // blanking
        convert(16'd1234, 1'b1, lat, bsy);
        check("blank_1234", 32'(bus.digits), 32'hF1234);
        convert(16'd0, 1'b1, lat, bsy);
        check("blank_zero", 32'(bus.digits), 32'hFFFF0);
        convert(16'd1000, 1'b1, lat, bsy);
        check("blank_1000", 32'(bus.digits), 32'hF1000);

        // start held through a conversion, inputs changed mid-flight
        bus.bin = 16'd42;
        bus.blank_lz = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                bus.bin = 16'd99;
                bus.blank_lz = 1'b1;
            end
        end
        check("hold_lat", lat, 16);
        check("hold_42", 32'(bus.digits), 32'h00042);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", lat, 16);
        check("b2b_99", 32'(bus.digits[1:0]), 32'h99);
        check("b2b_blank", 32'(bus.digits), 32'hFFF99);

        // async reset mid-conversion
        bus.bin = 16'd500;
        bus.blank_lz = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_digits", 32'(bus.digits), 0);
        #3 resetn = 1'b1;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 0);
        check("abort_idle", 32'(bus.busy), 0);

        // random scoreboard
        for (int n = 0; n < 1000; n++) begin
            rv = 16'($urandom);
            rb = 1'($urandom);
            if (n == 0) rv = 16'd9;
            if (n == 1) rv = 16'd10;
            if (n == 2) rv = 16'd9999;
            if (n == 3) rv = 16'd10000;
            convert(rv, rb, lat, bsy);
            check($sformatf("rnd_lat v=%0d", rv), lat, 16);
            check($sformatf("rnd v=%0d b=%0d", rv, rb), 32'(bus.digits), 32'(ref_bcd(rv, rb)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
